div_issue_stage: RTL and testbench

- Upstream operand-issue stage for the 64-bit combinational divider.
- Accepts tagged (a, b) operand pairs over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Presents each pair to the divider on registered operand outputs, then samples the divider result one cycle later.
- Returns result, tag and divide-by-zero flag over a valid/ready output interface.

---
 rtl/div_issue_stage.sv | 145 ++++++++++++++
 tb/tb_div_issue_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_stage.sv
// Operand-issue stage for the 64-bit combinational divider: buffers tagged
// operand pairs, drives the divider from registers and returns tagged results.
module div_issue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_a,
    input  logic [63:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [63:0]              div_a,
    output logic [63:0]              div_b,
    input  logic [63:0]              div_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_dbz,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [31:0]              dbz_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [TAG_W-1:0]   tag_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               capture;
    logic               accept;

    assign full     = (fifo_count == CNT_W'(DEPTH));
    assign empty    = (fifo_count == '0);
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & ~full;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = empty ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE:    pop = ~empty;
            ISSUE:   capture = 1'b1;
            HOLD: begin
                accept = out_ready;
                pop    = out_ready & ~empty;
            end
            default: ;
        endcase
    end

    // FIFO storage needs no reset; only pointers and count define occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, tag: in_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Operand issue, result capture and dbz accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a      <= '0;
            div_b      <= '0;
            tag_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
            out_dbz    <= 1'b0;
            out_valid  <= 1'b0;
            dbz_count  <= '0;
        end else begin
            if (pop) begin
                div_a <= mem[rd_ptr].a;
                div_b <= mem[rd_ptr].b;
                tag_q <= mem[rd_ptr].tag;
            end
            if (capture) begin
                out_result <= (div_b == 64'd0) ? 64'd0 : div_result;
                out_dbz    <= (div_b == 64'd0);
                out_tag    <= tag_q;
                out_valid  <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
                if (out_dbz && (dbz_count != 32'hFFFF_FFFF)) begin
                    dbz_count <= dbz_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage: table-driven single ops plus
// backpressure, streaming, mid-flight reset and dbz saturation sequences.
module tb_div_issue_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid;
    logic                  in_ready;
    logic [63:0]           in_a;
    logic [63:0]           in_b;
    logic [TAG_W-1:0]      in_tag;
    logic [63:0]           div_a;
    logic [63:0]           div_b;
    logic [63:0]           div_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_result;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_dbz;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [31:0]           dbz_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
        logic [63:0]      exp_q;
        logic             exp_dbz;
    } vec_t;

    vec_t vecs [8];
    vec_t bp   [5];

    div_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_dbz    (out_dbz),
        .fifo_count (fifo_count),
        .dbz_count  (dbz_count)
    );

    always #5 clk = ~clk;

    // Divider model; returns junk on divide-by-zero so masking is observable
    always_comb div_result = (div_b == 64'd0) ? 64'hDEAD_BEEF_0BAD_F00D : div_a / div_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        chk({name, "_valid_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic push_op(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
        int guard = 0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL push_timeout: in_ready stuck at 0");
        end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_dbz_cnt;
        int got;
        int last_cyc;
        logic [63:0] pa, pb;

        vecs[0] = '{64'd100, 64'd7, 4'd3, 64'd14, 1'b0};
        vecs[1] = '{64'd55, 64'd0, 4'd1, 64'd0, 1'b1};
        vecs[2] = '{64'd1000, 64'd10, 4'd2, 64'd100, 1'b0};
        vecs[3] = '{64'd7, 64'd8, 4'd4, 64'd0, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{64'd12345678, 64'd1000, 4'd9, 64'd12345, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'd2, 4'd6, 64'h4000_0000_0000_0000, 1'b0};
        vecs[7] = '{64'd0, 64'd0, 4'd0, 64'd0, 1'b1};

        bp[0] = '{64'd1000, 64'd10, 4'd5, 64'd100, 1'b0};
        bp[1] = '{64'd7, 64'd8, 4'd6, 64'd0, 1'b0};
        bp[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        bp[3] = '{64'd100, 64'd7, 4'd8, 64'd14, 1'b0};
        bp[4] = '{64'd81, 64'd9, 4'd9, 64'd9, 1'b0};

        in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_dbz_count", 64'(dbz_count), 64'd0);
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single op latency: push at N, pop at N+1, out_valid after N+2
        out_ready = 1'b1;
        push_op(64'd100, 64'd7, 4'd3);
        chk("lat_count_after_push", 64'(fifo_count), 64'd1);
        chk("lat_valid_n", 64'(out_valid), 64'd0);
        step();
        chk("lat_div_a", div_a, 64'd100);
        chk("lat_div_b", div_b, 64'd7);
        chk("lat_count_after_pop", 64'(fifo_count), 64'd0);
        chk("lat_valid_n1", 64'(out_valid), 64'd0);
        step();
        chk("lat_valid_n2", 64'(out_valid), 64'd1);
        chk("lat_result", out_result, 64'd14);
        chk("lat_tag", 64'(out_tag), 64'd3);
        chk("lat_dbz", 64'(out_dbz), 64'd0);
        step();
        chk("lat_valid_after_accept", 64'(out_valid), 64'd0);

        // Divide by zero with held result: dbz_count moves only on acceptance
        out_ready = 1'b0;
        push_op(64'd55, 64'd0, 4'd1);
        wait_valid("dbz");
        chk("dbz_result", out_result, 64'd0);
        chk("dbz_flag", 64'(out_dbz), 64'd1);
        chk("dbz_tag", 64'(out_tag), 64'd1);
        step();
        chk("dbz_held_valid", 64'(out_valid), 64'd1);
        chk("dbz_count_before", 64'(dbz_count), 64'd0);
        out_ready = 1'b1;
        step();
        chk("dbz_count_after", 64'(dbz_count), 64'd1);
        chk("dbz_valid_cleared", 64'(out_valid), 64'd0);
        exp_dbz_cnt = 1;

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            push_op(vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_q);
            chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
            chk($sformatf("vec%0d_dbz", i), 64'(out_dbz), 64'(vecs[i].exp_dbz));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            if (vecs[i].exp_dbz) exp_dbz_cnt++;
            chk($sformatf("vec%0d_dbz_count", i), 64'(dbz_count), 64'(exp_dbz_cnt));
            chk($sformatf("vec%0d_fifo_count", i), 64'(fifo_count), 64'd0);
        end

        // Backpressure: one op held in HOLD plus DEPTH queued, sixth refused
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_a = bp[i].a; in_b = bp[i].b; in_tag = bp[i].tag; in_valid = 1'b1;
            chk($sformatf("bp_ready_%0d", i), 64'(in_ready), 64'd1);
            step();
        end
        chk("bp_full_count", 64'(fifo_count), 64'd4);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        in_a = 64'd1; in_b = 64'd1; in_tag = 4'd10; in_valid = 1'b1;
        step();
        step();
        chk("bp_refused_count", 64'(fifo_count), 64'd4);
        chk("bp_refused_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                if (got < 5) begin
                    chk($sformatf("bp%0d_result", got), out_result, bp[got].exp_q);
                    chk($sformatf("bp%0d_tag", got), 64'(out_tag), 64'(bp[got].tag));
                end
                got++;
            end
            step();
        end
        chk("bp_result_count", 64'(got), 64'd5);
        chk("bp_drained_count", 64'(fifo_count), 64'd0);

        // Streaming: 8 back-to-back pushes, one result every 2 cycles
        out_ready = 1'b1;
        got = 0;
        last_cyc = -1;
        pa = div_a;
        pb = div_b;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int guard = 0;
                    in_a = 64'(1000 * (i + 1) + i); in_b = 64'(i + 3); in_tag = TAG_W'(i);
                    in_valid = 1'b1;
                    while (!in_ready && guard < 50) begin
                        step();
                        guard++;
                    end
                    step();
                end
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 60; cyc++) begin
                    if (out_valid) begin
                        if (got < 8) begin
                            chk($sformatf("st%0d_result", got), out_result,
                                64'(1000 * (got + 1) + got) / 64'(got + 3));
                            chk($sformatf("st%0d_tag", got), 64'(out_tag), 64'(got));
                            chk($sformatf("st%0d_issue_a", got), pa, 64'(1000 * (got + 1) + got));
                            chk($sformatf("st%0d_issue_b", got), pb, 64'(got + 3));
                        end
                        if (got > 0) chk($sformatf("st%0d_spacing", got), 64'(cyc - last_cyc), 64'd2);
                        last_cyc = cyc;
                        got++;
                    end
                    pa = div_a;
                    pb = div_b;
                    step();
                end
            end
        join
        chk("st_result_count", 64'(got), 64'd8);

        // Reset mid-flight while in ISSUE with two more ops queued
        out_ready = 1'b0;
        push_op(64'd30, 64'd3, 4'd1);
        in_a = 64'd40; in_b = 64'd4; in_tag = 4'd2; in_valid = 1'b1;
        step();
        in_a = 64'd50; in_b = 64'd5; in_tag = 4'd3;
        step();
        out_ready = 1'b1;
        in_a = 64'd60; in_b = 64'd6; in_tag = 4'd4;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mid_issue_valid", 64'(out_valid), 64'd0);
        chk("mid_issue_count", 64'(fifo_count), 64'd2);
        chk("mid_issue_div_a", div_a, 64'd40);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_div_a", div_a, 64'd0);
        chk("mid_rst_result", out_result, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 6; cyc++) begin
            chk($sformatf("post_rst_valid_%0d", cyc), 64'(out_valid), 64'd0);
            chk($sformatf("post_rst_count_%0d", cyc), 64'(fifo_count), 64'd0);
            step();
        end
        exp_dbz_cnt = 0;
        chk("post_rst_dbz_count", 64'(dbz_count), 64'd0);

        // Saturation of dbz_count
        force dut.dbz_count = 32'hFFFF_FFFF;
        #1 release dut.dbz_count;
        chk("sat_preset", 64'(dbz_count), 64'hFFFF_FFFF);
        push_op(64'd9, 64'd0, 4'd2);
        wait_valid("sat");
        chk("sat_dbz", 64'(out_dbz), 64'd1);
        step();
        chk("sat_valid_cleared", 64'(out_valid), 64'd0);
        chk("sat_count", 64'(dbz_count), 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
